// File: rtl/conv_kernel_pipe.sv
// conv_kernel_pipe: TAPS-tap fixed-point multiply-accumulate pipeline with
// NSET selectable weight/bias sets and valid/ready flow control.
//   S1: per-tap products and shifted bias captured from the selected set
//   S2: two partial sums (lower taps + bias, upper taps)
//   S3: final sum, round-half-up to DW bits, optional clamp -> o_data
// Optional feature: define CONV_KERNEL_RELU_EN to clamp negative results to 0.
module conv_kernel_pipe #(
  parameter int TAPS = 9,
  parameter int DW   = 20,
  parameter int FRAC = 16,
  parameter int NSET = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      i_valid,
  output logic                      i_ready,
  input  logic [TAPS*DW-1:0]        i_data,
  input  logic [$clog2(NSET)-1:0]   i_sel,
  input  logic                      w_we,
  input  logic [$clog2(NSET)-1:0]   w_set,
  input  logic [$clog2(TAPS+1)-1:0] w_idx,
  input  logic [DW-1:0]             w_data,
  output logic                      o_valid,
  input  logic                      o_ready,
  output logic [DW-1:0]             o_data
);

  localparam int PW   = 2 * DW;
  localparam int HALF = (TAPS + 1) / 2;
  localparam int SW   = $clog2(NSET);

  // Coefficient storage
  logic [DW-1:0] r_w [NSET][TAPS];
  logic [DW-1:0] r_b [NSET];

  // Pipeline registers
  logic          r_s1_v;
  logic [PW-1:0] r_s1_p [TAPS];
  logic [PW-1:0] r_s1_b;
  logic          r_s2_v;
  logic [PW-1:0] r_s2_lo;
  logic [PW-1:0] r_s2_hi;

  // Combinational nets
  logic          w_adv;
  logic [SW-1:0] w_sel;
  logic [PW-1:0] w_prod [TAPS];
  logic [PW-1:0] w_bias_ext;
  logic [PW-1:0] w_sum_lo;
  logic [PW-1:0] w_sum_hi;
  logic [PW-1:0] w_total;
  logic [DW-1:0] w_round;
  logic [DW-1:0] w_res;
  logic          w_unused_total;

  // Whole pipeline moves as one unit; input is accepted only when it moves
  assign w_adv   = !o_valid || o_ready;
  assign i_ready = w_adv;

  // Out-of-range set selects fall back to set 0
  always_comb begin
    w_sel = '0;
    if (int'(i_sel) < NSET) w_sel = i_sel;
  end

  // Coefficient writes; out-of-range set or index is dropped
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned s = 0; s < NSET; s++) begin
        for (int unsigned k = 0; k < TAPS; k++) r_w[s][k] <= '0;
        r_b[s] <= '0;
      end
    end else if (w_we && (int'(w_set) < NSET)) begin
      if (int'(w_idx) < TAPS)       r_w[w_set][w_idx] <= w_data;
      else if (int'(w_idx) == TAPS) r_b[w_set]        <= w_data;
    end
  end

  // S1 operands: explicit sign extension so every product is a full 2*DW wrap
  always_comb begin
    for (int unsigned k = 0; k < TAPS; k++) begin
      w_prod[k] = {{DW{i_data[k*DW+DW-1]}}, i_data[k*DW +: DW]}
                * {{DW{r_w[w_sel][k][DW-1]}}, r_w[w_sel][k]};
    end
    w_bias_ext = {{DW{r_b[w_sel][DW-1]}}, r_b[w_sel]} << FRAC;
  end

  // S1 register: products and bias frozen at acceptance
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1_v <= 1'b0;
      r_s1_b <= '0;
      for (int unsigned k = 0; k < TAPS; k++) r_s1_p[k] <= '0;
    end else if (w_adv) begin
      r_s1_v <= i_valid;
      if (i_valid) begin
        r_s1_b <= w_bias_ext;
        for (int unsigned k = 0; k < TAPS; k++) r_s1_p[k] <= w_prod[k];
      end
    end
  end

  // S2 partial sums: lower taps carry the bias
  always_comb begin
    w_sum_lo = r_s1_b;
    for (int unsigned k = 0; k < HALF; k++) w_sum_lo = w_sum_lo + r_s1_p[k];
    w_sum_hi = '0;
    for (int unsigned k = HALF; k < TAPS; k++) w_sum_hi = w_sum_hi + r_s1_p[k];
  end

  // S2 register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s2_v  <= 1'b0;
      r_s2_lo <= '0;
      r_s2_hi <= '0;
    end else if (w_adv) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_s2_lo <= w_sum_lo;
        r_s2_hi <= w_sum_hi;
      end
    end
  end

  // S3: final sum, round half up (wrapping), optional negative clamp
  always_comb begin
    w_total = r_s2_lo + r_s2_hi;
    w_round = w_total[FRAC +: DW] + DW'(w_total[FRAC-1]);
`ifdef CONV_KERNEL_RELU_EN
    w_res = w_round[DW-1] ? '0 : w_round;
`else
    w_res = w_round;
`endif
  end

  // Bits of the full-precision total that do not reach the output
  assign w_unused_total = ^{w_total[PW-1:FRAC+DW], w_total[FRAC-2:0]};

  // Output register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      o_valid <= 1'b0;
      o_data  <= '0;
    end else if (w_adv) begin
      o_valid <= r_s2_v;
      if (r_s2_v) o_data <= w_res;
    end
  end

endmodule

// File: tb/tb_conv_kernel_pipe.sv
// Directed self-checking bench for conv_kernel_pipe (default parameters).
// Expectations follow CONV_KERNEL_RELU_EN when it is defined for the build.
module tb_conv_kernel_pipe;

  localparam int TAPS = 9;
  localparam int DW   = 20;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 i_valid;
  logic                 i_ready;
  logic [TAPS*DW-1:0]   i_data;
  logic [0:0]           i_sel;
  logic                 w_we;
  logic [0:0]           w_set;
  logic [3:0]           w_idx;
  logic [DW-1:0]        w_data;
  logic                 o_valid;
  logic                 o_ready;
  logic [DW-1:0]        o_data;

  int n_checks = 0;
  int n_fail   = 0;

  conv_kernel_pipe #(.TAPS(TAPS), .DW(DW), .FRAC(16), .NSET(2)) dut (
    .clk(clk), .reset(reset),
    .i_valid(i_valid), .i_ready(i_ready), .i_data(i_data), .i_sel(i_sel),
    .w_we(w_we), .w_set(w_set), .w_idx(w_idx), .w_data(w_data),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data)
  );

  always #5 clk = ~clk;

  function automatic logic [TAPS*DW-1:0] tap0(input logic [DW-1:0] v);
    logic [TAPS*DW-1:0] x;
    x = '0;
    x[DW-1:0] = v;
    return x;
  endfunction

  task automatic do_reset();
    reset = 1'b0; i_valid = 1'b0; w_we = 1'b0; o_ready = 1'b1;
    i_data = '0; i_sel = '0; w_set = '0; w_idx = '0; w_data = '0;
    repeat (2) @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wr(input int s, input int idx, input logic [DW-1:0] d);
    w_we = 1'b1; w_set = s[0:0]; w_idx = idx[3:0]; w_data = d;
    @(posedge clk); #1 w_we = 1'b0;
  endtask

  // One sample with o_ready high; lat = edges from i_valid assertion to o_valid
  task automatic run_sample(input logic [TAPS*DW-1:0] d, input int sel,
                            output logic [DW-1:0] res, output int lat);
    i_data = d; i_sel = sel[0:0]; i_valid = 1'b1;
    res = 'x; lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1 i_valid = 1'b0;
      @(negedge clk);
      if (o_valid) begin res = o_data; lat = c; break; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    n_checks++;
    if ({o_valid, o_data, i_ready} !== {1'b0, 20'h0, 1'b1}) begin
      n_fail++;
      $display("FAIL reset_state: o_valid=%b o_data=%h i_ready=%b, required 0 00000 1",
               o_valid, o_data, i_ready);
    end
  endtask

  task automatic test_identity();
    logic [DW-1:0] res; int lat;
    wr(0, 0, 20'h10000);
    run_sample(tap0(20'h20000), 0, res, lat);
    n_checks++;
    if (res !== 20'h20000) begin
      n_fail++; $display("FAIL identity_data: got %h, required 20000", res);
    end
    n_checks++;
    if (lat !== 3) begin
      n_fail++; $display("FAIL identity_latency: got %0d, required 3", lat);
    end
  endtask

  task automatic test_negative();
    logic [DW-1:0] res, exp; int lat;
`ifdef CONV_KERNEL_RELU_EN
    exp = 20'h00000;
`else
    exp = 20'hE0000;
`endif
    wr(1, 0, 20'hF0000);
    run_sample(tap0(20'h20000), 1, res, lat);
    n_checks++;
    if (res !== exp) begin
      n_fail++; $display("FAIL negative_set1: got %h, required %h", res, exp);
    end
    run_sample(tap0(20'h20000), 0, res, lat);
    n_checks++;
    if (res !== 20'h20000) begin
      n_fail++; $display("FAIL set0_after_set1_write: got %h, required 20000", res);
    end
  endtask

  task automatic test_round_bias();
    logic [DW-1:0] res; int lat;
    wr(0, 0, 20'h08000);
    run_sample(tap0(20'h00001), 0, res, lat);
    n_checks++;
    if (res !== 20'h00001) begin
      n_fail++; $display("FAIL round_half_up: got %h, required 00001", res);
    end
    wr(0, 9, 20'h18000);
    run_sample('0, 0, res, lat);
    n_checks++;
    if (res !== 20'h18000) begin
      n_fail++; $display("FAIL bias_only: got %h, required 18000", res);
    end
    // -0.5 LSB product plus bias: 0x18000 - 0x0.8 rounds back to 0x18000
    wr(0, 0, 20'hF8000);
    run_sample(tap0(20'h00001), 0, res, lat);
    n_checks++;
    if (res !== 20'h18000) begin
      n_fail++; $display("FAIL round_negative_half: got %h, required 18000", res);
    end
    wr(0, 10, 20'h12345);
    wr(0, 12, 20'h7FFFF);
    run_sample(tap0(20'h00001), 0, res, lat);
    n_checks++;
    if (res !== 20'h18000) begin
      n_fail++; $display("FAIL ignored_index_write: got %h, required 18000", res);
    end
  endtask

  // w_k = (k+1)*0.5, tap_k = (k+1)*0x100 -> sum (k+1)^2*0x80 = 285*0x80 = 0x8E80, +bias 0x10
  task automatic test_all_taps();
    logic [DW-1:0] res; int lat;
    logic [TAPS*DW-1:0] d;
    do_reset();
    d = '0;
    for (int k = 0; k < TAPS; k++) begin
      wr(0, k, DW'((k + 1) * 32'h8000));
      d[k*DW +: DW] = DW'((k + 1) * 32'h100);
    end
    wr(0, 9, 20'h00010);
    run_sample(d, 0, res, lat);
    n_checks++;
    if (res !== 20'h08E90) begin
      n_fail++; $display("FAIL all_taps_sum: got %h, required 08e90", res);
    end
  endtask

  task automatic test_same_edge_write();
    logic [DW-1:0] res; int lat;
    do_reset();
    wr(0, 0, 20'h10000);
    w_we = 1'b1; w_set = 1'b0; w_idx = 4'd0; w_data = 20'h30000;
    run_sample(tap0(20'h20000), 0, res, lat);
    w_we = 1'b0;
    n_checks++;
    if (res !== 20'h20000) begin
      n_fail++; $display("FAIL same_edge_old_weight: got %h, required 20000", res);
    end
    run_sample(tap0(20'h20000), 0, res, lat);
    n_checks++;
    if (res !== 20'h60000) begin
      n_fail++; $display("FAIL new_weight_applied: got %h, required 60000", res);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] outs [4];
    int got, ptimeout, seen;
    do_reset();
    wr(0, 0, 20'h10000);
    got = 0; ptimeout = 0; seen = 0;
    fork
      begin : producer
        logic acc;
        for (int i = 0; i < 4; i++) begin
          i_data = tap0(DW'((i + 1) * 32'h1000));
          i_valid = 1'b1;
          acc = 1'b0;
          for (int c = 0; c < 40 && !acc; c++) begin
            @(negedge clk); #2 acc = i_ready;
            @(posedge clk); #1;
          end
          if (!acc) ptimeout++;
        end
        i_valid = 1'b0;
      end
      begin : consumer
        o_ready = 1'b1;
        for (int c = 0; c < 30; c++) begin
          @(negedge clk);
          if (o_valid) begin seen = 1; break; end
        end
        if (seen == 1) begin
          o_ready = 1'b0;
          for (int c = 0; c < 5; c++) begin
            @(negedge clk); #1;
            n_checks++;
            if ({i_ready, o_valid, o_data} !== {1'b0, 1'b1, 20'h01000}) begin
              n_fail++;
              $display("FAIL stall_hold cycle %0d: i_ready=%b o_valid=%b o_data=%h, required 0 1 01000",
                       c, i_ready, o_valid, o_data);
            end
          end
          o_ready = 1'b1;
          outs[0] = o_data; got = 1;
          for (int c = 0; c < 30 && got < 4; c++) begin
            @(negedge clk);
            if (o_valid) begin outs[got] = o_data; got++; end
          end
        end
      end
    join
    n_checks++;
    if (seen != 1 || got != 4 || ptimeout != 0) begin
      n_fail++;
      $display("FAIL b2b_delivery: first=%0d outputs=%0d producer_timeouts=%0d, required 1 4 0",
               seen, got, ptimeout);
    end
    for (int i = 0; i < 4; i++) begin
      if (i < got) begin
        n_checks++;
        if (outs[i] !== DW'((i + 1) * 32'h1000)) begin
          n_fail++;
          $display("FAIL b2b_order[%0d]: got %h, required %h", i, outs[i], DW'((i + 1) * 32'h1000));
        end
      end
    end
  endtask

  task automatic test_reset_inflight();
    logic [DW-1:0] res; int lat; int stale;
    do_reset();
    wr(0, 0, 20'h10000);
    for (int i = 0; i < 3; i++) begin
      i_data = tap0(DW'((i + 1) * 32'h2000)); i_valid = 1'b1;
      @(posedge clk); #1;
    end
    i_valid = 1'b0;
    n_checks++;
    if ({o_valid, o_data} !== {1'b1, 20'h02000}) begin
      n_fail++; $display("FAIL inflight_first_out: o_valid=%b o_data=%h, required 1 02000", o_valid, o_data);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({o_valid, o_data} !== {1'b0, 20'h0}) begin
      n_fail++; $display("FAIL async_clear: o_valid=%b o_data=%h, required 0 00000", o_valid, o_data);
    end
    @(negedge clk) reset = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (o_valid) stale++;
    end
    n_checks++;
    if (stale != 0 || i_ready !== 1'b1) begin
      n_fail++; $display("FAIL no_stale_output: stale=%0d i_ready=%b, required 0 1", stale, i_ready);
    end
    run_sample(tap0(20'h20000), 0, res, lat);
    n_checks++;
    if (res !== 20'h0 || lat !== 3) begin
      n_fail++; $display("FAIL coeffs_cleared: o_data=%h latency=%0d, required 00000 3", res, lat);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_negative();
    test_round_bias();
    test_all_taps();
    test_same_edge_write();
    test_back_to_back();
    test_reset_inflight();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
